// File: rtl/modexp_pkg.sv
// Shared types and sizing helpers for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int unsigned WIDTH_DEF   = 1024;
  localparam int unsigned E_WIDTH_DEF = 1024;

  // Width needed to hold a bit count in the range 0..e_width inclusive.
  function automatic int unsigned tw_of(input int unsigned e_width);
    return $clog2(e_width + 1);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SQ_START,
    SQ_WAIT,
    MUL_START,
    MUL_WAIT,
    FIN_START,
    FIN_WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_SQ,
    OP_MUL,
    OP_FIN
  } op_e;

endpackage

// File: rtl/modexp_exp_scan.sv
// Exponent register and scan index; walks e from bit t_eff-1 down to bit 0.
module modexp_exp_scan
  import modexp_pkg::*;
#(
  parameter int unsigned E_WIDTH = E_WIDTH_DEF,
  parameter int unsigned TW      = tw_of(E_WIDTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [E_WIDTH-1:0] e_in,
  input  logic [TW-1:0]      t_eff,
  input  logic               dec,
  output logic               cur_bit,
  output logic               last
);

  localparam int unsigned IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  logic [E_WIDTH-1:0] e_q, e_d;
  logic [IW-1:0]      idx_q, idx_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    e_d   = e_q;
    idx_d = idx_q;
    if (load) begin
      e_d   = e_in;
      idx_d = (t_eff == '0) ? '0 : IW'(t_eff - TW'(1));
    end else if (dec && (idx_q != '0)) begin
      idx_d = idx_q - IW'(1);
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q   <= '0;
      idx_q <= '0;
    end else begin
      e_q   <= e_d;
      idx_q <= idx_d;
    end
  end

  assign cur_bit = e_q[idx_q];
  assign last    = (idx_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery multiplier.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned E_WIDTH = E_WIDTH_DEF,
  parameter int unsigned TW      = tw_of(E_WIDTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x_tilde,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [TW-1:0]      in_t,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               mont_start,
  output logic [WIDTH-1:0]   mont_a,
  output logic [WIDTH-1:0]   mont_b,
  output logic [WIDTH-1:0]   mont_m,
  input  logic [WIDTH-1:0]   mont_result,
  input  logic               mont_done
);

  state_e           state_q, state_d;
  op_e              issue;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_tilde_q, x_tilde_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mont_a_q, mont_a_d;
  logic [WIDTH-1:0] mont_b_q, mont_b_d;
  logic             mont_start_q, mont_start_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [TW-1:0]    t_eff;
  logic             scan_load, scan_dec, cur_bit, last;

  assign t_eff = (in_t > TW'(E_WIDTH)) ? TW'(E_WIDTH) : in_t;

  modexp_exp_scan #(.E_WIDTH(E_WIDTH), .TW(TW)) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .load    (scan_load),
    .e_in    (in_e),
    .t_eff   (t_eff),
    .dec     (scan_dec),
    .cur_bit (cur_bit),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_tilde_d = x_tilde_q;
    m_d       = m_q;
    result_d  = result_q;
    mont_a_d  = mont_a_q;
    mont_b_d  = mont_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    scan_load = 1'b0;
    scan_dec  = 1'b0;
    issue     = OP_NONE;

    unique case (state_q)
      IDLE: if (start) begin
        scan_load = 1'b1;
        x_tilde_d = in_x_tilde;
        m_d       = in_m;
        acc_d     = in_r;
        busy_d    = 1'b1;
        issue     = (t_eff != '0) ? OP_SQ : OP_FIN;
      end
      SQ_START:  state_d = SQ_WAIT;
      SQ_WAIT: if (mont_done) begin
        acc_d = mont_result;
        if (cur_bit)   issue = OP_MUL;
        else if (last) issue = OP_FIN;
        else begin
          scan_dec = 1'b1;
          issue    = OP_SQ;
        end
      end
      MUL_START: state_d = MUL_WAIT;
      MUL_WAIT: if (mont_done) begin
        acc_d = mont_result;
        if (last) issue = OP_FIN;
        else begin
          scan_dec = 1'b1;
          issue    = OP_SQ;
        end
      end
      FIN_START: state_d = FIN_WAIT;
      FIN_WAIT: if (mont_done) begin
        result_d = mont_result;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands are loaded on entry to a *_START state and then held through its WAIT.
    case (issue)
      OP_SQ: begin
        state_d  = SQ_START;
        mont_a_d = acc_d;
        mont_b_d = acc_d;
      end
      OP_MUL: begin
        state_d  = MUL_START;
        mont_a_d = acc_d;
        mont_b_d = x_tilde_q;
      end
      OP_FIN: begin
        state_d  = FIN_START;
        mont_a_d = acc_d;
        mont_b_d = WIDTH'(1);
      end
      default: ;
    endcase
    mont_start_d = (issue != OP_NONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      x_tilde_q    <= '0;
      m_q          <= '0;
      result_q     <= '0;
      mont_a_q     <= '0;
      mont_b_q     <= '0;
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      x_tilde_q    <= x_tilde_d;
      m_q          <= m_d;
      result_q     <= result_d;
      mont_a_q     <= mont_a_d;
      mont_b_q     <= mont_b_d;
      mont_start_q <= mont_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign result     = result_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign mont_start = mont_start_q;
  assign mont_a     = mont_a_q;
  assign mont_b     = mont_b_q;
  assign mont_m     = m_q;

endmodule
